// File: rtl/sdrc_page_splitter_if.sv
// sdrc_page_splitter_if: application request and sub-request bus of the SDRAM page splitter
// Ports: cfg_colbits, req/req_addr/req_len/req_wr/req_ack (application side),
//        sub_req/sub_addr/sub_len/sub_wr/sub_last/sub_ack (request generator side), busy
interface sdrc_page_splitter_if #(
  parameter int APP_AW = 26,
  parameter int LEN_W  = 9
);
  logic [1:0]        cfg_colbits;
  logic              req;
  logic [APP_AW-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic              req_wr;
  logic              req_ack;
  logic              sub_req;
  logic [APP_AW-1:0] sub_addr;
  logic [LEN_W-1:0]  sub_len;
  logic              sub_wr;
  logic              sub_last;
  logic              sub_ack;
  logic              busy;
  modport slave (
    input  cfg_colbits, req, req_addr, req_len, req_wr, sub_ack,
    output req_ack, sub_req, sub_addr, sub_len, sub_wr, sub_last, busy
  );
  modport master (
    output cfg_colbits, req, req_addr, req_len, req_wr, sub_ack,
    input  req_ack, sub_req, sub_addr, sub_len, sub_wr, sub_last, busy
  );
endinterface

// File: rtl/sdrc_page_splitter.sv
// sdrc_page_splitter: splits one burst request into sub-requests that never cross an SDRAM page
// Ports: clk, reset (async, active-high), io (slave side of sdrc_page_splitter_if)
module sdrc_page_splitter #(
  parameter int APP_AW = 26,
  parameter int LEN_W  = 9
) (
  input logic                  clk,
  input logic                  reset,
  sdrc_page_splitter_if.slave  io
);
  typedef enum logic [1:0] {IDLE, SPLIT, ISSUE} state_t;
  state_t            state_q, state_d;
  logic [APP_AW-1:0] cur_addr_q, cur_addr_d, sub_addr_q, sub_addr_d;
  logic [LEN_W-1:0]  rem_len_q, rem_len_d, sub_len_q, sub_len_d, chunk;
  logic [1:0]        colbits_q, colbits_d;
  logic              wr_q, wr_d, req_ack_q, req_ack_d, sub_req_q, sub_req_d;
  logic              sub_wr_q, sub_wr_d, sub_last_q, sub_last_d;
  logic [11:0]       page_size, room;
  // room never exceeds chunk's width when it is chosen, since it is then <= rem_len
  always_comb begin
    page_size = 12'd256 << colbits_q;
    room      = page_size - ({1'b0, cur_addr_q[10:0]} & (page_size - 12'd1));
    chunk     = (12'(rem_len_q) < room) ? rem_len_q : LEN_W'(room);
  end
  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    rem_len_d  = rem_len_q;
    colbits_d  = colbits_q;
    wr_d       = wr_q;
    req_ack_d  = 1'b0;
    sub_req_d  = sub_req_q;
    sub_addr_d = sub_addr_q;
    sub_len_d  = sub_len_q;
    sub_wr_d   = sub_wr_q;
    sub_last_d = sub_last_q;
    case (state_q)
      IDLE: if (io.req && !req_ack_q) begin
        req_ack_d  = 1'b1;
        cur_addr_d = io.req_addr;
        rem_len_d  = io.req_len;
        wr_d       = io.req_wr;
        colbits_d  = io.cfg_colbits;
        state_d    = (io.req_len == '0 || io.req_len > LEN_W'(256)) ? IDLE : SPLIT;
      end
      SPLIT: begin
        sub_req_d  = 1'b1;
        sub_addr_d = cur_addr_q;
        sub_len_d  = chunk;
        sub_wr_d   = wr_q;
        sub_last_d = chunk == rem_len_q;
        state_d    = ISSUE;
      end
      ISSUE: if (io.sub_ack) begin
        sub_req_d  = 1'b0;
        cur_addr_d = cur_addr_q + APP_AW'(sub_len_q);
        rem_len_d  = rem_len_q - sub_len_q;
        state_d    = sub_last_q ? IDLE : SPLIT;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cur_addr_q <= '0;
      rem_len_q  <= '0;
      colbits_q  <= '0;
      wr_q       <= 1'b0;
      req_ack_q  <= 1'b0;
      sub_req_q  <= 1'b0;
      sub_addr_q <= '0;
      sub_len_q  <= '0;
      sub_wr_q   <= 1'b0;
      sub_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      rem_len_q  <= rem_len_d;
      colbits_q  <= colbits_d;
      wr_q       <= wr_d;
      req_ack_q  <= req_ack_d;
      sub_req_q  <= sub_req_d;
      sub_addr_q <= sub_addr_d;
      sub_len_q  <= sub_len_d;
      sub_wr_q   <= sub_wr_d;
      sub_last_q <= sub_last_d;
    end
  end
  assign io.req_ack  = req_ack_q;
  assign io.sub_req  = sub_req_q;
  assign io.sub_addr = sub_addr_q;
  assign io.sub_len  = sub_len_q;
  assign io.sub_wr   = sub_wr_q;
  assign io.sub_last = sub_last_q;
  assign io.busy     = state_q != IDLE;
endmodule

// File: doc/sdrc_page_splitter.md
Name: sdrc_page_splitter

Overview:
- Sits directly upstream of the request generator's address-increment adder.
- Accepts one application burst request: 26-bit word address, length of 1..256 words, direction.
- Splits the request at SDRAM page (column-wrap) boundaries into sub-requests, each confined to one row.
- Issues the sub-requests sequentially over a valid/ack handshake to the request generator.

Parameters:
- APP_AW, 26, application word-address width.
- LEN_W, 9, length field width; legal lengths 1..256.

Ports:
- clk  input  1  single clock; all logic rising-edge.
- reset  input  1  asynchronous, active-high reset.
- cfg_colbits  input  2  column bits per page: 0=8 (256 words), 1=9, 2=10, 3=11 (2048 words).
- req  input  1  application request valid; held until req_ack.
- req_addr  input  APP_AW  start word address.
- req_len  input  LEN_W  word count.
- req_wr  input  1  1=write, 0=read.
- req_ack  output  1  one-cycle pulse; request accepted.
- sub_req  output  1  sub-request valid.
- sub_addr  output  APP_AW  sub-request start address.
- sub_len  output  LEN_W  sub-request word count, 1..256.
- sub_wr  output  1  direction, copied from the latched request.
- sub_last  output  1  marks the final sub-request of the parent request.
- sub_ack  input  1  downstream accepts the current sub-request.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset: asserting reset immediately clears all outputs to 0 and forces state to IDLE, including mid-split. The in-flight request is discarded and no remaining sub-request is issued after release.
- States: IDLE, SPLIT, ISSUE.
- IDLE:
  - On req=1 at an edge: latch req_addr into cur_addr, req_len into rem_len, and latch req_wr and cfg_colbits.
  - req_ack=1 for exactly the next cycle; next state is SPLIT.
  - If req_len==0 or req_len>256: pulse req_ack, issue nothing, stay in IDLE.
- SPLIT (1 cycle):
  - page_size = 2^(8+colbits_latched); room = page_size - (cur_addr mod page_size).
  - chunk = min(rem_len, room).
  - Register sub_addr=cur_addr, sub_len=chunk, sub_wr, and sub_last=(chunk==rem_len).
  - Set sub_req=1; next state is ISSUE.
- ISSUE:
  - sub_req, sub_addr, sub_len, sub_wr and sub_last are held stable until sub_ack is sampled high.
  - On that edge: sub_req goes to 0, cur_addr += chunk modulo 2^APP_AW, rem_len -= chunk.
  - Next state is IDLE if sub_last, else SPLIT.
  - sub_ack while sub_req=0 is ignored.
- Timing:
  - Minimum latency from the req sample to sub_req high is 2 cycles.
  - Minimum spacing between successive sub_req assertions is 2 cycles (ack cycle plus SPLIT).
- Address arithmetic:
  - Unsigned, APP_AW bits; the carry out of the top bit is dropped (0x3FFFFFF + 1 = 0x0000000).
  - Page boundaries are computed on the full address, so a page boundary coincides with the wrap.
- Changes to cfg_colbits or req_* while busy have no effect on the request in flight.
- req held high while busy is not accepted until the return to IDLE. A new request may then be accepted in the IDLE cycle immediately following the last ack.
- req_ack is never asserted while busy=1, except in its own pulse cycle.

Test Plan:
- Page-internal request: colbits=0, req_addr=0x0000010, req_len=16 → one sub_req with addr 0x0000010, len 16, sub_last=1. req_ack pulses the cycle after the req sample; sub_req rises 2 cycles after the req sample.
- Single boundary crossing: colbits=0, req_addr=0x00000F0, len=32 → sub 1: addr 0x00000F0, len 16, last=0; sub 2: addr 0x0000100, len 16, last=1.
- Multi-page span: colbits=0, req_addr=0x00000FF, len=256 → sub 1: 0x00000FF/1; sub 2: 0x0000100/255, last=1. Repeat with colbits=3 → single sub 0x00000FF/256.
- Address wrap: colbits=0, req_addr=0x3FFFFF8, len=16 → sub 1: 0x3FFFFF8/8; sub 2: 0x0000000/8, last=1.
- Backpressure: hold sub_ack=0 for 10 cycles → sub_* stable throughout, busy=1. A second req during this window gets no req_ack until after the last ack.
- Reset and illegal length: assert reset during ISSUE of sub 1 of the boundary case → sub_req=0 and busy=0 immediately; no sub 2 after release. Separately, req_len=0 → req_ack pulse, no sub_req, busy stays 0.
